qspi_flash_reader: RTL and testbench

//   Boot/stream reader for the external QSPI flash on the qspi_dclk/qspi_ncs/qspi_data pins.

---
 rtl/qspi_flash_reader.sv | 211 +++++++++++++++++++++
 tb/tb_qspi_flash_reader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_flash_reader.sv
// qspi_flash_reader: issues a Quad Output Fast Read (0x6B) and streams the returned
// bytes over a valid/ready interface. When the sink is slow, the flash clock stalls.
// Ports:
//   clk_in_clk, reset_reset_n  clock, synchronous active-low reset
//   start, addr, len           request (sampled in IDLE), 24-bit address, byte count
//   busy, done                 transfer in progress, one-cycle completion pulse
//   rd_data, rd_valid, rd_ready  byte stream (valid/ready)
//   qspi_dclk, qspi_ncs        flash clock (mode 0) and chip select
//   qspi_data_o/_oe/_i         quad data pad drive, enable and sample
// DUMMY_CYCLES must be at least 1 and CLK_DIV at least 1.
module qspi_flash_reader #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned DUMMY_CYCLES = 8,
    parameter int unsigned LEN_W        = 16
) (
    input  logic             clk_in_clk,
    input  logic             reset_reset_n,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             qspi_dclk,
    output logic             qspi_ncs,
    output logic [3:0]       qspi_data_o,
    output logic [3:0]       qspi_data_oe,
    input  logic [3:0]       qspi_data_i
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DIV_W  = 16;
    localparam logic [7:0]  CMD_OP = 8'h6B;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_FINISH} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [30:0]        sr_q, sr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [7:0]         cap_q, cap_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dclk_q, dclk_d;
    logic               ncs_q, ncs_d;
    logic [3:0]         dout_q, dout_d;
    logic [3:0]         oe_q, oe_d;

    logic active_c, stall_c, run_c, tick_c, rise_c, fall_c, hs_c, finish_go_c;

    assign busy         = busy_q;
    assign done         = done_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign qspi_dclk    = dclk_q;
    assign qspi_ncs     = ncs_q;
    assign qspi_data_o  = dout_q;
    assign qspi_data_oe = oe_q;

    // A new byte may only begin once the previous one has left the holding register,
    // so the stall is taken with dclk low at the start of a byte.
    assign active_c    = (state_q == S_CMD) || (state_q == S_ADDR) ||
                         (state_q == S_DUMMY) || (state_q == S_DATA);
    assign hs_c        = rd_valid_q && rd_ready;
    assign stall_c     = (state_q == S_DATA) && !dclk_q && (cnt_q == '0) &&
                         rd_valid_q && !rd_ready;
    assign run_c       = active_c && !stall_c;
    assign tick_c      = run_c && (div_q == DIV_W'(CLK_DIV - 1));
    assign rise_c      = tick_c && !dclk_q;
    assign fall_c      = tick_c && dclk_q;
    assign finish_go_c = (state_q == S_FINISH) && (cnt_q >= CNT_W'(2 * CLK_DIV - 1)) &&
                         !rd_valid_q;

    // State and datapath registers.
    always_ff @(posedge clk_in_clk) begin
        if (!reset_reset_n) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            sr_q       <= '0;
            rem_q      <= '0;
            cap_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dclk_q     <= 1'b0;
            ncs_q      <= 1'b1;
            dout_q     <= '0;
            oe_q       <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            rem_q      <= rem_d;
            cap_q      <= cap_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dclk_q     <= dclk_d;
            ncs_q      <= ncs_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start && (len != '0)) state_d = S_CMD;
            S_CMD:    if (fall_c && (cnt_q == CNT_W'(7))) state_d = S_ADDR;
            S_ADDR:   if (fall_c && (cnt_q == CNT_W'(23))) state_d = S_DUMMY;
            S_DUMMY:  if (fall_c && (cnt_q == CNT_W'(DUMMY_CYCLES - 1))) state_d = S_DATA;
            S_DATA:   if (fall_c && (cnt_q == CNT_W'(2)) && (rem_q == LEN_W'(1)))
                          state_d = S_FINISH;
            S_FINISH: if (finish_go_c) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        div_d      = div_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        rem_d      = rem_q;
        cap_d      = cap_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dclk_d     = dclk_q;
        ncs_d      = ncs_q;
        dout_d     = dout_q;
        oe_d       = oe_q;

        if (hs_c) rd_valid_d = 1'b0;
        if (tick_c) dclk_d = ~dclk_q;

        // Divider is frozen while stalled and cleared whenever the bus is idle.
        if (!active_c) div_d = '0;
        else if (run_c) div_d = tick_c ? '0 : div_q + DIV_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        sr_d   = {CMD_OP[6:0], addr};
                        rem_d  = len;
                        busy_d = 1'b1;
                        ncs_d  = 1'b0;
                        dout_d = {3'b000, CMD_OP[7]};
                        oe_d   = 4'b0001;
                        cnt_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_CMD, S_ADDR: begin
                // Command then address leave one bit per falling tick on IO0.
                if (fall_c) begin
                    sr_d   = {sr_q[29:0], 1'b0};
                    dout_d = {3'b000, sr_q[30]};
                    cnt_d  = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
                    if (state_d == S_DUMMY) begin
                        dout_d = '0;
                        oe_d   = '0;
                    end
                end
            end
            S_DUMMY: begin
                if (fall_c) cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
            end
            S_DATA: begin
                // cnt: 0 = before high nibble, 1 = before low nibble, 2 = byte complete.
                if (rise_c) begin
                    if (cnt_q == '0) cap_d[7:4] = qspi_data_i;
                    else             cap_d[3:0] = qspi_data_i;
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (fall_c && (cnt_q == CNT_W'(2))) begin
                    rd_data_d  = cap_q;
                    rd_valid_d = 1'b1;
                    rem_d      = rem_q - LEN_W'(1);
                    cnt_d      = '0;
                    if (state_d == S_FINISH) ncs_d = 1'b1;
                end
            end
            S_FINISH: begin
                // cnt measures ncs-high time before done may pulse.
                if (cnt_q < CNT_W'(2 * CLK_DIV - 1)) cnt_d = cnt_q + CNT_W'(1);
                if (finish_go_c) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    cnt_d  = '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Directed bench for qspi_flash_reader: two instances (CLK_DIV=2 and CLK_DIV=1), each with
// a behavioural flash model decoding the command/address and returning a data pattern.
module tb_qspi_flash_reader;

    localparam int unsigned D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with CLK_DIV=2
    logic        rst2_n, start2, rdy2;
    logic [23:0] addr2;
    logic [15:0] len2;
    logic        busy2, done2, rval2, dclk2, ncs2;
    logic [7:0]  rdat2;
    logic [3:0]  do2, oe2;
    logic [3:0]  di2 = 4'h0;

    // Instance with CLK_DIV=1
    logic        rst1_n, start1, rdy1;
    logic [23:0] addr1;
    logic [15:0] len1;
    logic        busy1, done1, rval1, dclk1, ncs1;
    logic [7:0]  rdat1;
    logic [3:0]  do1, oe1;
    logic [3:0]  di1 = 4'h0;

    qspi_flash_reader #(.CLK_DIV(2), .DUMMY_CYCLES(D), .LEN_W(16)) u_dut2 (
        .clk_in_clk(clk), .reset_reset_n(rst2_n), .start(start2), .addr(addr2),
        .len(len2), .busy(busy2), .done(done2), .rd_data(rdat2), .rd_valid(rval2),
        .rd_ready(rdy2), .qspi_dclk(dclk2), .qspi_ncs(ncs2), .qspi_data_o(do2),
        .qspi_data_oe(oe2), .qspi_data_i(di2)
    );

    qspi_flash_reader #(.CLK_DIV(1), .DUMMY_CYCLES(D), .LEN_W(16)) u_dut1 (
        .clk_in_clk(clk), .reset_reset_n(rst1_n), .start(start1), .addr(addr1),
        .len(len1), .busy(busy1), .done(done1), .rd_data(rdat1), .rd_valid(rval1),
        .rd_ready(rdy1), .qspi_dclk(dclk1), .qspi_ncs(ncs1), .qspi_data_o(do1),
        .qspi_data_oe(oe1), .qspi_data_i(di1)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        case (i % 4)
            0:       return 8'hA5;
            1:       return 8'h3C;
            2:       return 8'h0F;
            default: return 8'hF0;
        endcase
    endfunction

    // Flash model for the CLK_DIV=2 instance
    int          f2_cnt = 0, f2_txn = 0, f2_edges = 0, f2_bad_oe = 0;
    logic [7:0]  f2_cmd = '0;
    logic [23:0] f2_addr = '0;

    always @(negedge ncs2) begin
        f2_cnt = 0;
        f2_txn++;
    end
    always @(posedge dclk2) begin
        f2_edges++;
        if (!ncs2) begin
            if (f2_cnt < 8)       f2_cmd  = {f2_cmd[6:0], do2[0]};
            else if (f2_cnt < 32) f2_addr = {f2_addr[22:0], do2[0]};
            if ((f2_cnt < 32 && oe2 !== 4'b0001) || (f2_cnt >= 32 && oe2 !== 4'b0000))
                f2_bad_oe++;
            f2_cnt++;
        end
    end
    always @(negedge dclk2) begin : flash2_drive
        int k;
        logic [7:0] b;
        if (!ncs2 && f2_cnt >= 32 + int'(D)) begin
            k   = f2_cnt - (32 + int'(D));
            b   = pat(k / 2);
            di2 = (k % 2 == 0) ? b[7:4] : b[3:0];
        end
    end

    // Flash model for the CLK_DIV=1 instance: incrementing byte pattern
    int          f1_cnt = 0, f1_bad_oe = 0;
    logic [7:0]  f1_cmd = '0;
    logic [23:0] f1_addr = '0;

    always @(negedge ncs1) f1_cnt = 0;
    always @(posedge dclk1) begin
        if (!ncs1) begin
            if (f1_cnt < 8)       f1_cmd  = {f1_cmd[6:0], do1[0]};
            else if (f1_cnt < 32) f1_addr = {f1_addr[22:0], do1[0]};
            if ((f1_cnt < 32 && oe1 !== 4'b0001) || (f1_cnt >= 32 && oe1 !== 4'b0000))
                f1_bad_oe++;
            f1_cnt++;
        end
    end
    always @(negedge dclk1) begin : flash1_drive
        int k;
        logic [7:0] b;
        if (!ncs1 && f1_cnt >= 32 + int'(D)) begin
            k   = f1_cnt - (32 + int'(D));
            b   = 8'(k / 2);
            di1 = (k % 2 == 0) ? b[7:4] : b[3:0];
        end
    end

    // Sink-side monitors, sampled on the falling clock edge
    logic [7:0] q2[$];
    logic [7:0] q1[$];
    int done_cnt2 = 0, done_cnt1 = 0, ncs_run2 = 0, ncs_before_done2 = 0;

    always @(negedge clk) begin
        if (rval2 && rdy2) q2.push_back(rdat2);
        if (done2) begin
            done_cnt2++;
            ncs_before_done2 = ncs_run2;
        end
        ncs_run2 = ncs2 ? ncs_run2 + 1 : 0;
        if (rval1 && rdy1) q1.push_back(rdat1);
        if (done1) done_cnt1++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done2(input string tag);
        int n = 0;
        while (!done2 && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, 32'(done2), 32'd1);
        tick();
        tick();
    endtask

    task automatic chk_q2(input string tag);
        chk({tag, "_count"}, 32'(q2.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_byte%0d", tag, i), (i < q2.size()) ? 32'(q2[i]) : 32'hx,
                32'(pat(i)));
    endtask

    initial begin
        int n, e0, t0, d0, first;

        rst2_n = 1'b0; start2 = 1'b0; rdy2 = 1'b1; addr2 = '0; len2 = '0;
        rst1_n = 1'b0; start1 = 1'b0; rdy1 = 1'b1; addr1 = '0; len1 = '0;
        repeat (3) tick();

        // Reset values
        chk("rst2_pins", 32'({busy2, done2, rval2, rdat2, dclk2, ncs2, do2, oe2}),
            32'({1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'h0, 4'h0}));
        chk("rst1_pins", 32'({busy1, done1, rval1, rdat1, dclk1, ncs1, do1, oe1}),
            32'({1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'h0, 4'h0}));
        rst2_n = 1'b1;
        rst1_n = 1'b1;
        tick();

        // 1: basic transfer, rd_ready always high
        q2.delete();
        addr2 = 24'h012345; len2 = 16'd4; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 1;
        chk("t1_busy", 32'(busy2), 32'd1);
        while (!rval2 && n < 1000) begin
            tick();
            n++;
        end
        chk("t1_latency_in_window", 32'(n >= 169 && n <= 170), 32'd1);
        wait_done2("t1_done_seen");
        chk("t1_busy_after", 32'(busy2), 32'd0);
        chk("t1_done_once", 32'(done_cnt2), 32'd1);
        chk("t1_cmd", 32'(f2_cmd), 32'h6B);
        chk("t1_addr", 32'(f2_addr), 32'h012345);
        chk("t1_ncs_before_done_ge4", 32'(ncs_before_done2 >= 4), 32'd1);
        chk_q2("t1");

        // 2: sink stalls for 50 cycles after the first byte
        q2.delete();
        d0 = done_cnt2;
        rdy2 = 1'b0;
        addr2 = 24'h012345; len2 = 16'd4; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (!rval2 && n < 1000) begin
            tick();
            n++;
        end
        repeat (10) tick();
        e0 = f2_edges;
        repeat (40) tick();
        chk("t2_no_dclk_edges", 32'(f2_edges), 32'(e0));
        chk("t2_dclk_low", 32'(dclk2), 32'd0);
        chk("t2_held_valid", 32'(rval2), 32'd1);
        chk("t2_held_byte", 32'(rdat2), 32'hA5);
        rdy2 = 1'b1;
        wait_done2("t2_done_seen");
        chk("t2_done_once", 32'(done_cnt2 - d0), 32'd1);
        chk_q2("t2");

        // 3: zero-length request
        q2.delete();
        e0 = f2_edges; t0 = f2_txn; d0 = done_cnt2;
        len2 = 16'd0; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("t3_done_pulse", 32'(done2), 32'd1);
        chk("t3_busy", 32'(busy2), 32'd0);
        chk("t3_ncs", 32'(ncs2), 32'd1);
        tick();
        chk("t3_done_cleared", 32'(done2), 32'd0);
        chk("t3_busy_after", 32'(busy2), 32'd0);
        chk("t3_no_dclk", 32'(f2_edges), 32'(e0));
        chk("t3_no_select", 32'(f2_txn), 32'(t0));
        tick();
        chk("t3_done_count", 32'(done_cnt2 - d0), 32'd1);

        // 4: reset during the address phase, then a clean transfer
        addr2 = 24'h111111; len2 = 16'd4; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (60) tick();
        chk("t4_in_addr_phase", 32'(f2_cnt >= 8 && f2_cnt < 32), 32'd1);
        d0 = done_cnt2;
        rst2_n = 1'b0;
        tick();
        chk("t4_rst_ncs", 32'(ncs2), 32'd1);
        chk("t4_rst_oe", 32'(oe2), 32'd0);
        chk("t4_rst_busy", 32'(busy2), 32'd0);
        chk("t4_rst_valid", 32'(rval2), 32'd0);
        chk("t4_rst_dclk", 32'(dclk2), 32'd0);
        rst2_n = 1'b1;
        tick();
        tick();
        chk("t4_no_done", 32'(done_cnt2), 32'(d0));
        q2.delete();
        addr2 = 24'h000010; len2 = 16'd4; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        wait_done2("t4_done_seen");
        chk("t4_addr", 32'(f2_addr), 32'h000010);
        chk_q2("t4");

        // 5: start while busy is ignored
        q2.delete();
        d0 = done_cnt2; t0 = f2_txn;
        addr2 = 24'h0ABCDE; len2 = 16'd4; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (100) tick();
        addr2 = 24'hFFFFFF; len2 = 16'd2; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("t5_busy", 32'(busy2), 32'd1);
        wait_done2("t5_done_seen");
        chk("t5_addr", 32'(f2_addr), 32'h0ABCDE);
        chk("t5_one_select", 32'(f2_txn - t0), 32'd1);
        chk("t5_done_once", 32'(done_cnt2 - d0), 32'd1);
        chk("t5_oe_clean", 32'(f2_bad_oe), 32'd0);
        chk_q2("t5");

        // 6: CLK_DIV=1, 256 incrementing bytes, random sink readiness
        q1.delete();
        addr1 = 24'h000100; len1 = 16'd256; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 1;
        first = 0;
        while (!done1 && n < 8000) begin
            if (rval1 && first == 0) first = n;
            rdy1 = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("t6_done_seen", 32'(done1), 32'd1);
        rdy1 = 1'b1;
        tick();
        tick();
        chk("t6_latency_in_window", 32'(first >= 85 && first <= 86), 32'd1);
        chk("t6_done_once", 32'(done_cnt1), 32'd1);
        chk("t6_cmd", 32'(f1_cmd), 32'h6B);
        chk("t6_addr", 32'(f1_addr), 32'h000100);
        chk("t6_oe_clean", 32'(f1_bad_oe), 32'd0);
        chk("t6_count", 32'(q1.size()), 32'd256);
        for (int i = 0; i < 256; i++)
            chk($sformatf("t6_byte%0d", i), (i < q1.size()) ? 32'(q1[i]) : 32'hx, 32'(i));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
